// File: rtl/uart_pkg.sv
// Shared constants and TX state encoding for the UART user-side bridge.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int BUSY_TIMEOUT_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy level; head is either fall-through or registered on pop.
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push;
    logic                  pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;

    // A pop frees the slot the push needs, so a full FIFO still accepts a write alongside a read.
    assign pop  = rd_en && !empty;
    assign push = wr_en && (!full || pop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data = empty ? '0 : mem_q[rdPtr_q];
        end else begin : g_reg
            logic [WIDTH-1:0] rdData_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdData_q <= '0;
                end else if (pop) begin
                    rdData_q <= mem_q[rdPtr_q];
                end
            end
            assign rd_data = rdData_q;
        end
    endgenerate

endmodule

// File: rtl/uart_usr_bridge.sv
// Host-side bridge to the UART controller usr_* port: queues TX bytes, issues one frame at a time,
// and buffers received bytes with sticky overflow tracking.
module uart_usr_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_en,
    input  logic                   tx_wr_en,
    input  logic [UART_DATA_W-1:0] tx_wr_data,
    output logic                   tx_full,
    output logic [DEPTH_LOG2:0]    tx_level,
    output logic                   tx_busy,
    input  logic                   rx_rd_en,
    output logic [UART_DATA_W-1:0] rx_rd_data,
    output logic                   rx_empty,
    output logic [DEPTH_LOG2:0]    rx_level,
    input  logic                   ovf_clr,
    output logic                   tx_ovf,
    output logic                   rx_ovf,
    output logic                   usr_start_tx,
    output logic [UART_DATA_W-1:0] usr_data_tx,
    input  logic                   usr_done_tx,
    input  logic                   usr_done_rx,
    input  logic [UART_DATA_W-1:0] usr_data_rx
);

    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    tx_state_e              state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   launch_q, launch_d;
    logic                   startTx_q, startTx_d;
    logic                   txPop;
    logic                   txEmpty;
    logic                   canLaunch;

    logic                   doneRxPrev_q;
    logic                   rxPush_q;
    logic [UART_DATA_W-1:0] rxData_q;
    logic                   rxFull;

    logic                   txOvf_q, rxOvf_q;
    logic                   txOvfSet, rxOvfSet;

    uart_sync_fifo #(
        .WIDTH      (UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .FWFT       (1'b1)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (txPop),
        .rd_data (usr_data_tx),
        .full    (tx_full),
        .empty   (txEmpty),
        .level   (tx_level)
    );

    uart_sync_fifo #(
        .WIDTH      (UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .FWFT       (1'b1)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rxPush_q),
        .wr_data (rxData_q),
        .rd_en   (rx_rd_en),
        .rd_data (rx_rd_data),
        .full    (rxFull),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    assign canLaunch = !txEmpty && uart_en && usr_done_tx;

    // The launch condition is registered once in S_IDLE before S_START is entered; this sets the
    // write-to-pulse latency and guarantees idle cycles between frames.
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        txPop     = 1'b0;
        launch_d  = (state_q == S_IDLE) && canLaunch;
        case (state_q)
            S_IDLE: begin
                if (launch_q && canLaunch) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!usr_done_tx) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (usr_done_tx) begin
                    txPop   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        startTx_d = (state_d == S_START);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            launch_q  <= 1'b0;
            startTx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            launch_q  <= launch_d;
            startTx_q <= startTx_d;
        end
    end

    assign usr_start_tx = startTx_q;
    assign tx_busy      = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            doneRxPrev_q <= 1'b0;
            rxPush_q     <= 1'b0;
            rxData_q     <= '0;
        end else begin
            doneRxPrev_q <= usr_done_rx;
            rxPush_q     <= usr_done_rx && !doneRxPrev_q;
            if (usr_done_rx && !doneRxPrev_q) begin
                rxData_q <= usr_data_rx;
            end
        end
    end

    // A read in the same cycle makes room, so only an unrelieved full FIFO counts as overflow.
    assign txOvfSet = tx_wr_en && tx_full && !txPop;
    assign rxOvfSet = rxPush_q && rxFull && !rx_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            txOvf_q <= 1'b0;
            rxOvf_q <= 1'b0;
        end else begin
            if (txOvfSet) begin
                txOvf_q <= 1'b1;
            end else if (ovf_clr) begin
                txOvf_q <= 1'b0;
            end
            if (rxOvfSet) begin
                rxOvf_q <= 1'b1;
            end else if (ovf_clr) begin
                rxOvf_q <= 1'b0;
            end
        end
    end

    assign tx_ovf = txOvf_q;
    assign rx_ovf = rxOvf_q;

endmodule

// File: tb/tb_uart_usr_bridge.sv
// Directed bench for uart_usr_bridge with a behavioural controller model and TX/RX scoreboards.
module tb_uart_usr_bridge;

    logic       clk;
    logic       rst;
    logic       uart_en;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       tx_busy;
    logic       rx_rd_en;
    logic [7:0] rx_rd_data;
    logic       rx_empty;
    logic [4:0] rx_level;
    logic       ovf_clr;
    logic       tx_ovf;
    logic       rx_ovf;
    logic       usr_start_tx;
    logic [7:0] usr_data_tx;
    logic       usr_done_tx;
    logic       usr_done_rx;
    logic [7:0] usr_data_rx;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] expQ[$];
    logic [7:0] rxExp[$];

    bit         stallMode = 1'b0;
    int         busyLen = 4;
    int         busyCnt = 0;
    int         pulseCount = 0;
    logic       prevStart = 1'b0;
    logic [7:0] curByte = 8'h00;

    uart_usr_bridge #(
        .DEPTH_LOG2   (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_en      (uart_en),
        .tx_wr_en     (tx_wr_en),
        .tx_wr_data   (tx_wr_data),
        .tx_full      (tx_full),
        .tx_level     (tx_level),
        .tx_busy      (tx_busy),
        .rx_rd_en     (rx_rd_en),
        .rx_rd_data   (rx_rd_data),
        .rx_empty     (rx_empty),
        .rx_level     (rx_level),
        .ovf_clr      (ovf_clr),
        .tx_ovf       (tx_ovf),
        .rx_ovf       (rx_ovf),
        .usr_start_tx (usr_start_tx),
        .usr_data_tx  (usr_data_tx),
        .usr_done_tx  (usr_done_tx),
        .usr_done_rx  (usr_done_rx),
        .usr_data_rx  (usr_data_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model: accepts a frame on each start pulse unless stalled, holds done_tx low busyLen cycles.
    initial begin
        usr_done_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                usr_done_tx = 1'b1;
                busyCnt     = 0;
                prevStart   = 1'b0;
            end else begin
                if (busyCnt > 0) begin
                    busyCnt--;
                    if (busyCnt == 0) begin
                        usr_done_tx = 1'b1;
                        check("data_stable", usr_data_tx, curByte);
                    end
                end
                if (usr_start_tx) begin
                    pulseCount++;
                    check("start_when_idle", usr_done_tx, 1'b1);
                    check("start_single", prevStart, 1'b0);
                    if (!stallMode) begin
                        curByte = usr_data_tx;
                        check("tx_expected", expQ.size() != 0, 1'b1);
                        if (expQ.size() != 0) begin
                            check("tx_order", usr_data_tx, expQ.pop_front());
                        end
                        usr_done_tx = 1'b0;
                        busyCnt     = busyLen;
                    end
                end
                prevStart = usr_start_tx;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic writeByte(input logic [7:0] b);
        @(negedge clk);
        tx_wr_en   = 1'b1;
        tx_wr_data = b;
        @(posedge clk);
        #1 tx_wr_en = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (!(tx_level == 0 && !tx_busy && expQ.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 300, 1'b1);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int pc0;
        int n;
        rst         = 1'b1;
        uart_en     = 1'b1;
        tx_wr_en    = 1'b0;
        tx_wr_data  = 8'h00;
        rx_rd_en    = 1'b0;
        ovf_clr     = 1'b0;
        usr_done_rx = 1'b0;
        usr_data_rx = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_tx_full", tx_full, 1'b0);
        check("rst_tx_level", tx_level, 5'd0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_rx_level", rx_level, 5'd0);
        check("rst_rx_rd_data", rx_rd_data, 8'h00);
        check("rst_ovf", {tx_ovf, rx_ovf}, 2'b00);
        check("rst_start", usr_start_tx, 1'b0);
        check("rst_data_tx", usr_data_tx, 8'h00);

        // Single byte: pulse lands in the cycle after edge k+2.
        @(negedge clk);
        tx_wr_en   = 1'b1;
        tx_wr_data = 8'hA5;
        expQ.push_back(8'hA5);
        @(posedge clk);
        #1 tx_wr_en = 1'b0;
        @(negedge clk);
        check("lat_k0", usr_start_tx, 1'b0);
        @(negedge clk);
        check("lat_k1", usr_start_tx, 1'b0);
        @(negedge clk);
        check("lat_k2", usr_start_tx, 1'b1);
        check("lat_level1", tx_level, 5'd1);
        check("lat_data", usr_data_tx, 8'hA5);
        @(negedge clk);
        check("pulse_width", usr_start_tx, 1'b0);
        check("level_held", tx_level, 5'd1);
        waitDrain("drain_a5");
        check("level_zero", tx_level, 5'd0);

        // Three back-to-back bytes go out in order, one pulse each.
        pc0 = pulseCount;
        for (int i = 1; i <= 3; i++) begin
            expQ.push_back(8'(i));
            writeByte(8'(i));
        end
        waitDrain("drain_three");
        check("three_pulses", pulseCount - pc0, 3);

        // Disabled, then enabled with a controller that never goes busy.
        uart_en = 1'b0;
        pc0 = pulseCount;
        writeByte(8'h55);
        repeat (10) @(negedge clk);
        check("no_pulse_disabled", pulseCount - pc0, 0);
        check("queued_disabled", tx_level, 5'd1);
        stallMode = 1'b1;
        uart_en   = 1'b1;
        repeat (30) @(negedge clk);
        check("retries_seen", (pulseCount - pc0) >= 3, 1'b1);
        check("retry_no_pop", tx_level, 5'd1);
        expQ.push_back(8'h55);
        stallMode = 1'b0;
        waitDrain("drain_retry");

        // Fill TX FIFO with frames blocked.
        uart_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            writeByte(8'h80 + 8'(i));
        end
        @(negedge clk);
        check("tx_full16", tx_full, 1'b1);
        check("tx_level16", tx_level, 5'd16);
        check("tx_ovf_pre", tx_ovf, 1'b0);
        writeByte(8'hFF);
        @(negedge clk);
        check("tx_ovf_set", tx_ovf, 1'b1);
        check("tx_level_hold", tx_level, 5'd16);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("tx_ovf_clr", tx_ovf, 1'b0);
        pulseReset();
        @(negedge clk);
        check("flush_level", tx_level, 5'd0);
        uart_en = 1'b1;

        // 17 received bytes with no reads.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            usr_data_rx = 8'h10 + 8'(i);
            usr_done_rx = 1'b1;
            if (i < 16) rxExp.push_back(8'h10 + 8'(i));
            @(negedge clk);
            usr_done_rx = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rx_level16", rx_level, 5'd16);
        check("rx_ovf_set", rx_ovf, 1'b1);
        check("rx_not_empty", rx_empty, 1'b0);
        n = rxExp.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rx_data", rx_rd_data, rxExp.pop_front());
            rx_rd_en = 1'b1;
            @(posedge clk);
            #1 rx_rd_en = 1'b0;
        end
        @(negedge clk);
        check("rx_empty_end", rx_empty, 1'b1);
        check("rx_level_end", rx_level, 5'd0);

        // Reset in S_WAIT_DONE with five bytes queued.
        busyLen = 40;
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(8'h61 + 8'(i));
            writeByte(8'h61 + 8'(i));
        end
        n = 0;
        while (!(tx_busy && !usr_done_tx) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_done", n < 50, 1'b1);
        repeat (2) @(negedge clk);
        check("pre_rst_level", tx_level, 5'd5);
        check("pre_rst_rx_ovf", rx_ovf, 1'b1);
        pulseReset();
        @(negedge clk);
        check("post_rst_busy", tx_busy, 1'b0);
        check("post_rst_level", tx_level, 5'd0);
        check("post_rst_start", usr_start_tx, 1'b0);
        check("post_rst_flags", {tx_ovf, rx_ovf}, 2'b00);
        check("post_rst_rx_empty", rx_empty, 1'b1);
        expQ.delete();
        busyLen = 4;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
